pll_reset_sequencer: RTL and testbench

//  Sits directly downstream of the PLL wrapper, clocked by its 16 MHz output.

---
 rtl/pll_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Core reset sequencer fed by the PLL output clock: synchronises the lock flag,
// releases reset after a stable-lock window and generates a slow clock-enable tick.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int HOLD_CYCLES    = 16,
    parameter int CE_DIV         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       ext_rst_req,
    output logic       sys_rst_n,
    output logic       ce_tick,
    output logic [1:0] state,
    output logic [7:0] lock_lost_cnt,
    output logic       timeout_err
);

    localparam int MAX_AB  = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CE_DIV - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_STABILIZE = 2'b01,
        ST_RUN       = 2'b10,
        ST_HOLD      = 2'b11
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic                 tick_reg, tick_next;
    logic                 sys_rst_n_reg;
    logic [7:0]           lost_reg, lost_next;
    logic                 timeout_reg, timeout_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                 lock_s;
    logic                 lock_eff;
    logic                 lock_loss;

    // Each stage samples the one before it; stage 0 takes the raw PLL flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= pll_lock;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign lock_s = sync_reg[SYNC_STAGES-1];
    // After a lock timeout the flag is no longer trusted; the core runs regardless.
    assign lock_eff = lock_s | timeout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_WAIT_LOCK;
            cnt_reg       <= '0;
            div_reg       <= '0;
            tick_reg      <= 1'b0;
            sys_rst_n_reg <= 1'b0;
            lost_reg      <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            div_reg       <= div_next;
            tick_reg      <= tick_next;
            sys_rst_n_reg <= (state_next == ST_RUN);
            lost_reg      <= lost_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout_reg;
        lock_loss    = 1'b0;
        case (state_reg)
            ST_WAIT_LOCK: begin
                if (lock_eff) begin
                    state_next = ST_STABILIZE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!lock_eff) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // RUN is only held while lock is high, so a low lock here is a fall.
                lock_loss = ~lock_eff;
                if (!lock_eff || ext_rst_req) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            default: state_next = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if ((state_next != state_reg) || (state_reg == ST_RUN)) begin
            cnt_next = '0;
        end
    end

    always_comb begin
        lost_next = lost_reg;
        if (lock_loss && (lost_reg != 8'hFF)) begin
            lost_next = lost_reg + 8'd1;
        end
    end

    // Divider restarts from zero on every RUN entry, so the first tick lands CE_DIV edges after release.
    always_comb begin
        div_next  = '0;
        tick_next = 1'b0;
        if ((state_reg == ST_RUN) && (state_next == ST_RUN)) begin
            if (div_reg == DIV_LAST) begin
                tick_next = 1'b1;
            end else begin
                div_next = div_reg + 1'b1;
            end
        end
    end

    assign sys_rst_n     = sys_rst_n_reg;
    assign ce_tick       = tick_reg;
    assign state         = state_reg;
    assign lock_lost_cnt = lost_reg;
    assign timeout_err   = timeout_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC=2, STABLE=8, TIMEOUT=100, HOLD=16, CE_DIV=4.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       ext_rst_req;
    logic       sys_rst_n;
    logic       ce_tick;
    logic [1:0] state;
    logic [7:0] lock_lost_cnt;
    logic       timeout_err;

    int checks = 0;
    int fails  = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(100),
        .HOLD_CYCLES   (16),
        .CE_DIV        (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .ext_rst_req  (ext_rst_req),
        .sys_rst_n    (sys_rst_n),
        .ce_tick      (ce_tick),
        .state        (state),
        .lock_lost_cnt(lock_lost_cnt),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until state==s, or -1 if the bound expires.
    task automatic wait_for_state(input logic [1:0] s, input int max_edges, output int n);
        n = -1;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (state === s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic lock);
        @(negedge clk);
        rst_n = 1'b0;
        ext_rst_req = 1'b0;
        pll_lock = lock;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({state, sys_rst_n, ce_tick, lock_lost_cnt, timeout_err} !== 13'b0) begin
            fails++;
            $display("FAIL reset_state: got state=%b sys_rst_n=%b ce=%b lost=%0d to=%b, expected all zero",
                     state, sys_rst_n, ce_tick, lock_lost_cnt, timeout_err);
        end
        $display("reset: state=%b sys_rst_n=%b", state, sys_rst_n);
    endtask

    task automatic test_t1_lock_from_start();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        wait_for_state(2'b10, 40, n);
        checks++;
        if (n !== 11) begin
            fails++;
            $display("FAIL t1_latency: got %0d edges to RUN, expected 11", n);
        end
        checks++;
        if (sys_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL t1_sys_rst_n: got %b, expected 1", sys_rst_n);
        end
        $display("t1: RUN after %0d edges, sys_rst_n=%b", n, sys_rst_n);
    endtask

    task automatic test_t2_drop_in_stabilize();
        int n;
        do_reset(1'b0);
        repeat (5) tick();
        pll_lock = 1'b1;
        wait_for_state(2'b01, 10, n);
        checks++;
        if (n < 0) begin
            fails++;
            $display("FAIL t2_enter_stab: timed out, expected STABILIZE");
        end
        repeat (3) tick();
        pll_lock = 1'b0;
        repeat (2) tick();
        checks++;
        if (state !== 2'b01) begin
            fails++;
            $display("FAIL t2_still_stab: got state=%b, expected 01", state);
        end
        tick();
        checks++;
        if (state !== 2'b00 || sys_rst_n !== 1'b0) begin
            fails++;
            $display("FAIL t2_back_to_wait: got state=%b sys_rst_n=%b, expected 00/0", state, sys_rst_n);
        end
        pll_lock = 1'b1;
        wait_for_state(2'b01, 10, n);
        checks++;
        if (n !== 3) begin
            fails++;
            $display("FAIL t2_relock: got %0d edges to STABILIZE, expected 3", n);
        end
        wait_for_state(2'b10, 20, n);
        checks++;
        if (n !== 8 || sys_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL t2_full_window: got %0d edges sys_rst_n=%b, expected 8/1", n, sys_rst_n);
        end
        $display("t2: re-lock window %0d edges", n);
    endtask

    task automatic test_t3_lock_losses();
        int n;
        for (int k = 1; k <= 3; k++) begin
            pll_lock = 1'b0;
            wait_for_state(2'b11, 10, n);
            checks++;
            if (n !== 3 || sys_rst_n !== 1'b0 || lock_lost_cnt !== 8'(k)) begin
                fails++;
                $display("FAIL t3_loss%0d: got edges=%0d sys_rst_n=%b lost=%0d, expected 3/0/%0d",
                         k, n, sys_rst_n, lock_lost_cnt, k);
            end
            pll_lock = 1'b1;
            wait_for_state(2'b10, 60, n);
            checks++;
            if (n !== 25 || sys_rst_n !== 1'b1) begin
                fails++;
                $display("FAIL t3_low_len%0d: got reset low %0d edges sys_rst_n=%b, expected 25/1", k, n, sys_rst_n);
            end
            $display("t3: loss %0d, reset low %0d cycles, lost=%0d", k, n, lock_lost_cnt);
        end
    endtask

    task automatic test_t5_ce_and_combined();
        int n;
        int hold_n;
        int ce_in_hold;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (ce_tick !== ((i % 4) == 0)) begin
                fails++;
                $display("FAIL t5_ce_edge%0d: got %b, expected %b", i, ce_tick, ((i % 4) == 0));
            end
        end
        ext_rst_req = 1'b1;
        tick();
        ext_rst_req = 1'b0;
        checks++;
        if (state !== 2'b11 || lock_lost_cnt !== 8'd3 || ce_tick !== 1'b0) begin
            fails++;
            $display("FAIL t5_ext_only: got state=%b lost=%0d ce=%b, expected 11/3/0", state, lock_lost_cnt, ce_tick);
        end
        wait_for_state(2'b10, 60, n);
        checks++;
        if (n !== 25) begin
            fails++;
            $display("FAIL t5_ext_recover: got %0d edges, expected 25", n);
        end
        pll_lock = 1'b0;
        repeat (2) tick();
        ext_rst_req = 1'b1;
        tick();
        ext_rst_req = 1'b0;
        pll_lock = 1'b1;
        checks++;
        if (state !== 2'b11 || lock_lost_cnt !== 8'd4) begin
            fails++;
            $display("FAIL t5_combined: got state=%b lost=%0d, expected 11/4", state, lock_lost_cnt);
        end
        hold_n = 1;
        ce_in_hold = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state !== 2'b11) break;
            hold_n++;
            if (ce_tick !== 1'b0) ce_in_hold++;
        end
        checks++;
        if (hold_n !== 16 || state !== 2'b00 || ce_in_hold !== 0) begin
            fails++;
            $display("FAIL t5_single_hold: got hold=%0d next=%b ce_in_hold=%0d, expected 16/00/0",
                     hold_n, state, ce_in_hold);
        end
        $display("t5: combined event, hold=%0d lost=%0d", hold_n, lock_lost_cnt);
    endtask

    task automatic test_t4_timeout();
        int n;
        do_reset(1'b0);
        ext_rst_req = 1'b1;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (timeout_err === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 100 || state !== 2'b01) begin
            fails++;
            $display("FAIL t4_timeout: got %0d edges state=%b, expected 100/01", n, state);
        end
        ext_rst_req = 1'b0;
        wait_for_state(2'b10, 20, n);
        checks++;
        if (n !== 8 || sys_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL t4_run_after: got %0d edges sys_rst_n=%b, expected 8/1", n, sys_rst_n);
        end
        repeat (20) tick();
        checks++;
        if (state !== 2'b10 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL t4_lock_ignored: got state=%b to=%b, expected 10/1", state, timeout_err);
        end
        $display("t4: timeout then RUN, state=%b", state);
    endtask

    task automatic test_t6_reset_and_saturate();
        int n;
        ext_rst_req = 1'b1;
        tick();
        ext_rst_req = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, sys_rst_n, ce_tick, lock_lost_cnt, timeout_err} !== 13'b0) begin
            fails++;
            $display("FAIL t6_async_reset: got state=%b sys_rst_n=%b ce=%b lost=%0d to=%b, expected all zero",
                     state, sys_rst_n, ce_tick, lock_lost_cnt, timeout_err);
        end
        @(negedge clk);
        pll_lock = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            wait_for_state(2'b10, 60, n);
            if (n < 0) begin
                checks++;
                fails++;
                $display("FAIL t6_run_wait: timed out at loss %0d", k);
                break;
            end
            pll_lock = 1'b0;
            wait_for_state(2'b11, 10, n);
            pll_lock = 1'b1;
            if (n < 0) begin
                checks++;
                fails++;
                $display("FAIL t6_hold_wait: timed out at loss %0d", k);
                break;
            end
            if (k == 255) begin
                checks++;
                if (lock_lost_cnt !== 8'd255) begin
                    fails++;
                    $display("FAIL t6_cnt255: got %0d, expected 255", lock_lost_cnt);
                end
            end
        end
        checks++;
        if (lock_lost_cnt !== 8'd255) begin
            fails++;
            $display("FAIL t6_saturate: got %0d, expected 255", lock_lost_cnt);
        end
        $display("t6: after 256 losses lost=%0d", lock_lost_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        pll_lock = 1'b1;
        ext_rst_req = 1'b0;
        test_reset();
        test_t1_lock_from_start();
        test_t2_drop_in_stabilize();
        test_t3_lock_losses();
        test_t5_ce_and_combined();
        test_t4_timeout();
        test_t6_reset_and_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
